// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared state encoding and display constants for the scan controller
package seven_seg_pkg;
  typedef enum logic {GUARD = 1'b0, SHOW = 1'b1} scan_state_t;
  localparam int MAX_DIGITS = 8;
  localparam logic ANODE_OFF = 1'b1;
  localparam logic ANODE_ON = 1'b0;
  localparam logic [3:0] BCD_DP_ONLY = 4'hA;
endpackage

// File: rtl/seven_seg_lz_mask.sv
// seven_seg_lz_mask: per-slot visibility from enables and leading-zero suppression
module seven_seg_lz_mask #(
  parameter int NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   en,
  input  logic                    lz,
  output logic [NUM_DIGITS-1:0]   visible
);
  logic zero_run;
  always_comb begin
    visible = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (digits[4*i +: 4] == 4'd0);
      visible[i] = en[i] & ~(lz & zero_run & (i != 0));
    end
  end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed 7-segment anode scanner with guard gaps and
// tear-free double-buffered frame loading
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SHOW_CYCLES = 100000,
  parameter int GUARD_CYCLES = 2000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    lz_blank_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [3:0]              Q,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);
  localparam int TMAX = SHOW_CYCLES > GUARD_CYCLES ? SHOW_CYCLES : GUARD_CYCLES;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  scan_state_t state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [IW-1:0] idx, idx_d;
  logic [4*NUM_DIGITS-1:0] act_digits, pend_digits;
  logic [NUM_DIGITS-1:0] act_en, pend_en, vis, anode_d;
  logic act_lz, pend_lz, pend_full;
  logic guard_done, show_done, last, wrap;
  logic [3:0] q_d;

  seven_seg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
    .digits (act_digits),
    .en     (act_en),
    .lz     (act_lz),
    .visible(vis)
  );

  assign load_ready = ~pend_full;

  always_comb begin
    last = idx == IW'(NUM_DIGITS - 1);
    guard_done = state == GUARD && timer == TW'(GUARD_CYCLES - 1);
    show_done = state == SHOW && timer == TW'(SHOW_CYCLES - 1);
    wrap = show_done & last;
    state_d = guard_done ? SHOW : show_done ? GUARD : state;
    timer_d = (guard_done | show_done) ? '0 : timer + 1'b1;
    idx_d = show_done ? (last ? '0 : idx + 1'b1) : idx;
    q_d = state == GUARD ? act_digits[4*idx +: 4] : Q;
    anode_d = {NUM_DIGITS{ANODE_OFF}};
    if (state == SHOW && vis[idx]) anode_d[idx] = ANODE_ON;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= GUARD;
      timer <= '0;
      idx <= '0;
      act_digits <= '0;
      act_en <= '0;
      act_lz <= 1'b0;
      pend_digits <= '0;
      pend_en <= '0;
      pend_lz <= 1'b0;
      pend_full <= 1'b0;
      anode <= {NUM_DIGITS{ANODE_OFF}};
      Q <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      idx <= idx_d;
      anode <= anode_d;
      Q <= q_d;
      frame_start <= wrap;
      // swap only at the frame boundary so a displayed frame never tears
      if (wrap && pend_full) begin
        act_digits <= pend_digits;
        act_en <= pend_en;
        act_lz <= pend_lz;
        pend_full <= 1'b0;
      end else if (load_valid && !pend_full) begin
        pend_digits <= digits_in;
        pend_en <= digit_en_in;
        pend_lz <= lz_blank_in;
        pend_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: random and directed frames against a frame-arithmetic reference model
module tb_seven_seg_scan_ctrl;
  localparam int N = 4;
  localparam int SC = 8;
  localparam int GC = 2;
  localparam int SLOT = SC + GC;
  localparam int FRAME = N * SLOT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0] digit_en_in = '0;
  logic lz_blank_in = 1'b0;
  logic load_valid = 1'b0;
  logic load_ready;
  logic [3:0] Q;
  logic [N-1:0] anode;
  logic frame_start;

  int n_total = 0;
  int n_pass = 0;

  int s = 0;
  logic [4*N-1:0] m_dig = '0, p_dig = '0;
  logic [N-1:0] m_en = '0, p_en = '0;
  logic m_lz = 1'b0, p_lz = 1'b0, m_pend = 1'b0;
  logic [3:0] exp_q = 4'd0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .SHOW_CYCLES(SC), .GUARD_CYCLES(GC)) dut (
    .clk(clk),
    .reset(reset),
    .digits_in(digits_in),
    .digit_en_in(digit_en_in),
    .lz_blank_in(lz_blank_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .Q(Q),
    .anode(anode),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic visible(input int i);
    return m_en[i] && !(m_lz && i != 0 && (m_dig >> (4*i)) == 0);
  endfunction

  task automatic tick();
    int slot, ph;
    logic [N-1:0] ea;
    logic [3:0] eq;
    logic ef;
    slot = (s / SLOT) % N;
    ph = s % SLOT;
    ea = '1;
    if (ph >= GC && visible(slot)) ea[slot] = 1'b0;
    eq = ph < GC ? m_dig[4*slot +: 4] : exp_q;
    ef = (s + 1) % FRAME == 0;
    check("load_ready", load_ready, !m_pend);
    if (ef && m_pend) begin
      m_dig = p_dig; m_en = p_en; m_lz = p_lz; m_pend = 1'b0;
    end else if (load_valid && !m_pend) begin
      p_dig = digits_in; p_en = digit_en_in; p_lz = lz_blank_in; m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    s++;
    exp_q = eq;
    check("anode", anode, ea);
    check("Q", Q, eq);
    check("frame_start", frame_start, ef);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] e, input logic l);
    digits_in = d; digit_en_in = e; lz_blank_in = l; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_anode", anode, 4'hF);
    check("reset_Q", Q, 0);
    check("reset_ready", load_ready, 1);
    check("reset_fs", frame_start, 0);
    run(FRAME);
    load(16'h1234, 4'hF, 1'b0);
    run(2 * FRAME);
    load(16'h0050, 4'hF, 1'b1);
    run(2 * FRAME);
    load(16'h0000, 4'hF, 1'b1);
    run(2 * FRAME);
    load(16'h0000, 4'hE, 1'b1);
    run(2 * FRAME);
    load(16'h8765, 4'hF, 1'b0);
    digits_in = 16'h4321; digit_en_in = 4'hF; lz_blank_in = 1'b0; load_valid = 1'b1;
    run(10);
    load_valid = 1'b0;
    run(FRAME);
    load(16'h4321, 4'hF, 1'b0);
    run(2 * FRAME);
    repeat (700) begin
      for (int i = 0; i < N; i++)
        digits_in[4*i +: 4] = $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(0, 15));
      digit_en_in = 4'($urandom);
      lz_blank_in = 1'($urandom);
      load_valid = $urandom_range(0, 7) == 0;
      tick();
    end
    load_valid = 1'b0;
    while (s % FRAME != 1) tick();
    load(16'h9876, 4'hF, 1'b0);
    while (s % FRAME != 2 * SLOT + GC + 3) tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_anode", anode, 4'hF);
    check("async_Q", Q, 0);
    check("async_ready", load_ready, 1);
    check("async_fs", frame_start, 0);
    s = 0; m_dig = '0; m_en = '0; m_lz = 1'b0; m_pend = 1'b0; exp_q = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    run(2 * FRAME);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
